wb_arbiter_3: RTL and testbench
===============================

# wb_arbiter_3

Three-master to one-slave Wishbone arbiter. It sits upstream of the 3-port address-decoding mux so that instruction fetch (m0), data load/store (m1) and a DMA/debug port (m2) share one bus. Arbitration is round-robin, and a grant is held for a whole `cyc` burst. A bus watchdog returns `err` to a master whose strobe goes unanswered.

## Interface

Parameters:
- `DATA_WIDTH`, 32, data bus width in bits
- `ADDR_WIDTH`, 32, address bus width in bits
- `SELECT_WIDTH`, `DATA_WIDTH/8`, byte-select width
- `TIMEOUT_CYCLES`, 255, number of stalled strobe cycles before `err`; 0 disables the watchdog

Ports (N = 0..2, one set per master):
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `wb_mN_adr_i` input `ADDR_WIDTH`: master N address
- `wb_mN_dat_i` input `DATA_WIDTH`: master N write data
- `wb_mN_dat_o` output `DATA_WIDTH`: read data to master N
- `wb_mN_we_i` input 1: master N write enable
- `wb_mN_sel_i` input `SELECT_WIDTH`: master N byte select
- `wb_mN_stb_i` input 1: master N strobe
- `wb_mN_cyc_i` input 1: master N cycle / bus request
- `wb_mN_ack_o`, `wb_mN_err_o`, `wb_mN_rty_o` output 1 each: responses to master N
- `wb_s_adr_o`, `wb_s_dat_o`, `wb_s_we_o`, `wb_s_sel_o` output (`ADDR_WIDTH`, `DATA_WIDTH`, 1, `SELECT_WIDTH`): forwarded from the granted master
- `wb_s_stb_o`, `wb_s_cyc_o` output 1 each: strobe and cycle to the slave
- `wb_s_dat_i` input `DATA_WIDTH`: slave read data
- `wb_s_ack_i`, `wb_s_err_i`, `wb_s_rty_i` input 1 each: slave responses
- `gnt_o` output 3: one-hot registered grant (status/debug)

## Operation

- States: `IDLE` and `GRANT`.
- `IDLE`:
  - All slave outputs are 0.
  - If any `wb_mN_cyc_i` is high, pick the first requester in the order `last+1`, `last+2`, `last` (mod 3).
  - Register `gnt_o` and go to `GRANT`.
- `GRANT`:
  - The slave port carries the granted master's `adr`, `dat`, `we`, `sel`, `stb` and `cyc` combinationally.
  - `wb_s_dat_i`, `ack`, `err` and `rty` are routed only to the granted master.
  - Non-granted masters see `dat_o` = 0 and `ack`/`err`/`rty` = 0.
- Release: when the granted master's `cyc_i` is low, go to `IDLE`, set `last` to the granted index, and clear `gnt_o`. There is no preemption while `cyc_i` stays high, across any number of strobes.
- Watchdog counter, width `$clog2(TIMEOUT_CYCLES+1)`:
  - Increments each `GRANT` cycle with `stb_i & cyc_i & ~(ack|err|rty)`.
  - Clears on any slave response, on `stb_i` low, or on leaving `GRANT`.
  - When count == `TIMEOUT_CYCLES` and there is no slave response: assert `err_o` to the granted master for that cycle, force `wb_s_cyc_o`/`wb_s_stb_o` low for that cycle, and clear the counter.
- Simultaneous events:
  - A slave response in the timeout cycle wins: it is passed through, and no watchdog `err` is raised.
  - A request arriving on the same cycle as a release is seen in the following `IDLE` cycle.

## Timing

- Reset (async on `rst_n` low) gives: state `IDLE`, `gnt_o` = 0, `last` = 2 (so m0 wins first), counter = 0. Every slave-side output and every master response/`dat_o` is 0 while in reset.
- Grant latency: a request sampled in `IDLE` at edge k drives the slave from cycle k+1.
- Response path: zero-cycle combinational passthrough in both directions.
- Back-to-back: release at edge k puts the arbiter in `IDLE` for one cycle. The next grant is visible at k+2, so there is one bubble per handover.
- Watchdog `err` arrives in the (`TIMEOUT_CYCLES`+1)th consecutive stalled strobe cycle.

## Structure

- The shared `wb_pkg` holds the state enum (`IDLE`, `GRANT`) and the master-index type (2 bits).
- One sub-module, `rr_pick3`, is natural: a combinational round-robin selector taking 3 requests plus a last index and returning a one-hot pick.
- The watchdog stays inline.

## Test plan

- Reset; m1 reads 0x8000_0000; slave acks 2 cycles later with 0xDEADBEEF. Expect `gnt_o`=3'b010 one cycle after the request, and m1 receives `ack` and 0xDEADBEEF. m0/m2 `ack`=0 and `dat_o`=0.
- All masters hold `cyc` continuously; each one drops `cyc` after one ack, then re-requests. Expect grant order m0, m1, m2, m0, with one bubble cycle per handover.
- m0 holds `cyc` across 3 strobes while m2 requests. Expect m2 ungranted until m0 drops `cyc`, then `gnt_o`=3'b100 two cycles later.
- `TIMEOUT_CYCLES`=4 and the slave never responds. Expect the granted master's `err_o` high on the 5th stalled cycle and slave `cyc`/`stb` low in that cycle. The counter restarts if `stb` persists.
- `TIMEOUT_CYCLES`=4 and the slave acks in exactly the 5th stalled cycle. Expect `ack` to be passed through and no `err`.
- `rst_n` low mid-grant. Expect all outputs 0 immediately with no clock edge. After release, with m0 and m1 both requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the 3-master Wishbone arbiter
package wb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [1:0] midx_t;

  // m2 counts as the last winner after reset so m0 is served first
  localparam midx_t RESET_LAST = 2'd2;

  // Next master index, modulo 3
  function automatic midx_t midx_next(input midx_t i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] midx_onehot(input midx_t i);
    return 3'b001 << i;
  endfunction

  // Index of a one-hot grant; an empty grant maps to 0 and is gated elsewhere
  function automatic midx_t onehot_midx(input logic [2:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational round-robin selector over three requesters
module rr_pick3
  import wb_pkg::*;
(
  input  logic [2:0] i_req,
  input  midx_t      i_last,
  output logic [2:0] o_pick
);

  midx_t w_first;
  midx_t w_second;
  midx_t w_third;

  assign w_first  = midx_next(i_last);
  assign w_second = midx_next(w_first);
  assign w_third  = i_last;

  // Search order last+1, last+2, last; the previous winner goes to the back
  always_comb begin
    o_pick = 3'b000;
    if (i_req[w_first])       o_pick = midx_onehot(w_first);
    else if (i_req[w_second]) o_pick = midx_onehot(w_second);
    else if (i_req[w_third])  o_pick = midx_onehot(w_third);
  end

endmodule

// File: rtl/wb_arbiter_3.sv
// rtl/wb_arbiter_3.sv - three-master round-robin Wishbone arbiter with bus watchdog
module wb_arbiter_3
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wb_m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_m0_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_m0_dat_o,
  input  logic                    wb_m0_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_m0_sel_i,
  input  logic                    wb_m0_stb_i,
  input  logic                    wb_m0_cyc_i,
  output logic                    wb_m0_ack_o,
  output logic                    wb_m0_err_o,
  output logic                    wb_m0_rty_o,
  input  logic [ADDR_WIDTH-1:0]   wb_m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_m1_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_m1_dat_o,
  input  logic                    wb_m1_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_m1_sel_i,
  input  logic                    wb_m1_stb_i,
  input  logic                    wb_m1_cyc_i,
  output logic                    wb_m1_ack_o,
  output logic                    wb_m1_err_o,
  output logic                    wb_m1_rty_o,
  input  logic [ADDR_WIDTH-1:0]   wb_m2_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_m2_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_m2_dat_o,
  input  logic                    wb_m2_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_m2_sel_i,
  input  logic                    wb_m2_stb_i,
  input  logic                    wb_m2_cyc_i,
  output logic                    wb_m2_ack_o,
  output logic                    wb_m2_err_o,
  output logic                    wb_m2_rty_o,
  output logic [ADDR_WIDTH-1:0]   wb_s_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_s_dat_o,
  output logic                    wb_s_we_o,
  output logic [SELECT_WIDTH-1:0] wb_s_sel_o,
  output logic                    wb_s_stb_o,
  output logic                    wb_s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_s_dat_i,
  input  logic                    wb_s_ack_i,
  input  logic                    wb_s_err_i,
  input  logic                    wb_s_rty_i,
  output logic [2:0]              gnt_o
);

  // Counter is kept 1 bit wide when the watchdog is disabled so widths stay legal
  localparam int             CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT_CYCLES);

  arb_state_e r_state;
  logic [2:0] r_gnt;
  midx_t      r_last;
  logic [CW-1:0] r_wd_cnt;

  logic [ADDR_WIDTH-1:0]   w_adr [3];
  logic [DATA_WIDTH-1:0]   w_wdat [3];
  logic [SELECT_WIDTH-1:0] w_sel [3];
  logic [DATA_WIDTH-1:0]   w_rdat [3];
  logic [2:0] w_we, w_stb, w_cyc;
  logic [2:0] w_ack, w_err, w_rty;
  logic [2:0] w_pick;
  midx_t      w_idx;
  logic       w_granted, w_g_cyc, w_g_stb, w_resp, w_stall, w_timeout;

  assign w_adr[0]  = wb_m0_adr_i;  assign w_adr[1]  = wb_m1_adr_i;  assign w_adr[2]  = wb_m2_adr_i;
  assign w_wdat[0] = wb_m0_dat_i;  assign w_wdat[1] = wb_m1_dat_i;  assign w_wdat[2] = wb_m2_dat_i;
  assign w_sel[0]  = wb_m0_sel_i;  assign w_sel[1]  = wb_m1_sel_i;  assign w_sel[2]  = wb_m2_sel_i;
  assign w_we  = {wb_m2_we_i,  wb_m1_we_i,  wb_m0_we_i};
  assign w_stb = {wb_m2_stb_i, wb_m1_stb_i, wb_m0_stb_i};
  assign w_cyc = {wb_m2_cyc_i, wb_m1_cyc_i, wb_m0_cyc_i};

  rr_pick3 u_pick (
    .i_req  (w_cyc),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  assign w_idx     = onehot_midx(r_gnt);
  assign w_granted = (r_state == GRANT) && (r_gnt != 3'b000);
  assign w_g_cyc   = w_granted & w_cyc[w_idx];
  assign w_g_stb   = w_granted & w_stb[w_idx];
  assign w_resp    = wb_s_ack_i | wb_s_err_i | wb_s_rty_i;
  assign w_stall   = w_g_stb & w_g_cyc & ~w_resp;
  // A slave response in the same cycle suppresses the watchdog via w_stall
  assign w_timeout = (TIMEOUT_CYCLES > 0) && w_stall && (r_wd_cnt == TO_VAL);
  assign gnt_o     = r_gnt;

  // Grant FSM: pick in IDLE, hold the grant until the owner drops cyc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 3'b000;
      r_last  <= RESET_LAST;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_cyc) begin
            r_gnt   <= w_pick;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!w_cyc[w_idx]) begin
            r_last  <= w_idx;
            r_gnt   <= 3'b000;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= 3'b000;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Watchdog: count consecutive unanswered strobe cycles, restart after firing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if ((TIMEOUT_CYCLES == 0) || !w_stall || w_timeout) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  // Forward the owner's request to the slave; the timeout cycle drops the bus
  always_comb begin
    wb_s_adr_o = '0;
    wb_s_dat_o = '0;
    wb_s_we_o  = 1'b0;
    wb_s_sel_o = '0;
    wb_s_stb_o = 1'b0;
    wb_s_cyc_o = 1'b0;
    if (w_granted) begin
      wb_s_adr_o = w_adr[w_idx];
      wb_s_dat_o = w_wdat[w_idx];
      wb_s_we_o  = w_we[w_idx];
      wb_s_sel_o = w_sel[w_idx];
      wb_s_stb_o = w_g_stb & ~w_timeout;
      wb_s_cyc_o = w_g_cyc & ~w_timeout;
    end
  end

  // Route slave responses only to the owner; everyone else sees zeros
  always_comb begin
    w_ack = 3'b000;
    w_err = 3'b000;
    w_rty = 3'b000;
    for (int i = 0; i < 3; i++) w_rdat[i] = '0;
    if (w_granted) begin
      w_ack[w_idx]  = wb_s_ack_i;
      w_err[w_idx]  = wb_s_err_i | w_timeout;
      w_rty[w_idx]  = wb_s_rty_i;
      w_rdat[w_idx] = wb_s_dat_i;
    end
  end

  assign wb_m0_dat_o = w_rdat[0];  assign wb_m1_dat_o = w_rdat[1];  assign wb_m2_dat_o = w_rdat[2];
  assign wb_m0_ack_o = w_ack[0];   assign wb_m1_ack_o = w_ack[1];   assign wb_m2_ack_o = w_ack[2];
  assign wb_m0_err_o = w_err[0];   assign wb_m1_err_o = w_err[1];   assign wb_m2_err_o = w_err[2];
  assign wb_m0_rty_o = w_rty[0];   assign wb_m1_rty_o = w_rty[1];   assign wb_m2_rty_o = w_rty[2];

endmodule

// File: tb/tb_wb_arbiter_3.sv
// tb/tb_wb_arbiter_3.sv - directed self-checking bench for wb_arbiter_3
module tb_wb_arbiter_3;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_adr [3];
  logic [31:0] m_wdat [3];
  logic [31:0] m_rdat [3];
  logic [3:0]  m_sel [3];
  logic [2:0]  m_we, m_stb, m_cyc;
  logic [2:0]  m_ack, m_err, m_rty;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_we, s_stb, s_cyc;
  logic        s_ack, s_err, s_rty;
  logic [2:0]  gnt;

  int n_tests = 0;
  int n_fail  = 0;
  int order [4] = '{0, 1, 2, 0};

  wb_arbiter_3 #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .SELECT_WIDTH   (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_m0_adr_i (m_adr[0]),  .wb_m0_dat_i (m_wdat[0]), .wb_m0_dat_o (m_rdat[0]),
    .wb_m0_we_i  (m_we[0]),   .wb_m0_sel_i (m_sel[0]),  .wb_m0_stb_i (m_stb[0]),
    .wb_m0_cyc_i (m_cyc[0]),  .wb_m0_ack_o (m_ack[0]),  .wb_m0_err_o (m_err[0]),
    .wb_m0_rty_o (m_rty[0]),
    .wb_m1_adr_i (m_adr[1]),  .wb_m1_dat_i (m_wdat[1]), .wb_m1_dat_o (m_rdat[1]),
    .wb_m1_we_i  (m_we[1]),   .wb_m1_sel_i (m_sel[1]),  .wb_m1_stb_i (m_stb[1]),
    .wb_m1_cyc_i (m_cyc[1]),  .wb_m1_ack_o (m_ack[1]),  .wb_m1_err_o (m_err[1]),
    .wb_m1_rty_o (m_rty[1]),
    .wb_m2_adr_i (m_adr[2]),  .wb_m2_dat_i (m_wdat[2]), .wb_m2_dat_o (m_rdat[2]),
    .wb_m2_we_i  (m_we[2]),   .wb_m2_sel_i (m_sel[2]),  .wb_m2_stb_i (m_stb[2]),
    .wb_m2_cyc_i (m_cyc[2]),  .wb_m2_ack_o (m_ack[2]),  .wb_m2_err_o (m_err[2]),
    .wb_m2_rty_o (m_rty[2]),
    .wb_s_adr_o  (s_adr),
    .wb_s_dat_o  (s_wdat),
    .wb_s_we_o   (s_we),
    .wb_s_sel_o  (s_sel),
    .wb_s_stb_o  (s_stb),
    .wb_s_cyc_o  (s_cyc),
    .wb_s_dat_i  (s_rdat),
    .wb_s_ack_i  (s_ack),
    .wb_s_err_i  (s_err),
    .wb_s_rty_i  (s_rty),
    .gnt_o       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      m_adr[i]  = 32'h1000_0000 * (i + 1);
      m_wdat[i] = 32'hA0A0_0000 + i;
      m_sel[i]  = 4'hF;
    end
    m_we  = 3'b000;
    m_stb = 3'b000;
    m_cyc = 3'b000;
    s_rdat = 32'h0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state
    tick();
    settle();
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_scyc", 64'(s_cyc), 64'h0);
    check("rst_sstb", 64'(s_stb), 64'h0);
    rst_n = 1'b1;
    tick();

    // m1 single read, acked two cycles after grant
    m_adr[1] = 32'h8000_0000;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    settle();
    check("rd_idle_gnt", 64'(gnt), 64'h0);
    check("rd_idle_scyc", 64'(s_cyc), 64'h0);
    tick();
    settle();
    check("rd_gnt", 64'(gnt), 64'h2);
    check("rd_sadr", 64'(s_adr), 64'h8000_0000);
    check("rd_scyc", 64'(s_cyc), 64'h1);
    tick();
    tick();
    s_ack  = 1'b1;
    s_rdat = 32'hDEAD_BEEF;
    settle();
    check("rd_m1_ack", 64'(m_ack), 64'h2);
    check("rd_m1_dat", 64'(m_rdat[1]), 64'hDEAD_BEEF);
    check("rd_m0_dat", 64'(m_rdat[0]), 64'h0);
    check("rd_m2_dat", 64'(m_rdat[2]), 64'h0);
    tick();
    s_ack = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    tick();
    settle();
    check("rd_release_gnt", 64'(gnt), 64'h0);

    // Round robin with all masters requesting, one bubble per handover
    do_reset();
    m_cyc = 3'b111;
    m_stb = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      settle();
      check($sformatf("rr_gnt%0d", n), 64'(gnt), 64'(1) << order[n]);
      check($sformatf("rr_sadr%0d", n), 64'(s_adr), 64'(m_adr[order[n]]));
      s_ack = 1'b1;
      settle();
      check($sformatf("rr_ack%0d", n), 64'(m_ack), 64'(1) << order[n]);
      tick();
      s_ack = 1'b0;
      m_cyc[order[n]] = 1'b0;
      m_stb[order[n]] = 1'b0;
      tick();
      settle();
      check($sformatf("rr_bubble%0d", n), 64'(gnt), 64'h0);
      m_cyc[order[n]] = 1'b1;
      m_stb[order[n]] = 1'b1;
    end

    // m0 keeps cyc across three strobes; m2 waits
    do_reset();
    m_cyc = 3'b101;
    m_stb[2] = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      m_stb[0] = 1'b1;
      s_ack = 1'b1;
      settle();
      check($sformatf("hold_gnt%0d", s), 64'(gnt), 64'h1);
      check($sformatf("hold_ack%0d", s), 64'(m_ack), 64'h1);
      tick();
      m_stb[0] = 1'b0;
      s_ack = 1'b0;
      settle();
      check($sformatf("hold_gap%0d", s), 64'(gnt), 64'h1);
      tick();
    end
    m_cyc[0] = 1'b0;
    tick();
    settle();
    check("hold_bubble", 64'(gnt), 64'h0);
    tick();
    settle();
    check("hold_m2_gnt", 64'(gnt), 64'h4);
    check("hold_m2_sadr", 64'(s_adr), 64'(m_adr[2]));

    // Watchdog fires on the 5th and again on the 10th stalled cycle
    do_reset();
    m_adr[0] = 32'h0000_1000;
    m_we[0]  = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      settle();
      check($sformatf("wd_err%0d", k), 64'(m_err), (k == 5 || k == 10) ? 64'h1 : 64'h0);
      check($sformatf("wd_scyc%0d", k), 64'(s_cyc), (k == 5 || k == 10) ? 64'h0 : 64'h1);
      check($sformatf("wd_sstb%0d", k), 64'(s_stb), (k == 5 || k == 10) ? 64'h0 : 64'h1);
      tick();
    end
    settle();
    check("wd_still_gnt", 64'(gnt), 64'h1);
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    tick();

    // Slave ack in the 5th stalled cycle beats the watchdog
    do_reset();
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    settle();
    check("race_gnt", 64'(gnt), 64'h2);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) s_ack = 1'b1;
      settle();
      check($sformatf("race_err%0d", k), 64'(m_err), 64'h0);
      if (k == 5) begin
        check("race_ack", 64'(m_ack), 64'h2);
        check("race_sstb", 64'(s_stb), 64'h1);
      end
      tick();
    end

    // Asynchronous reset mid-grant, then m0 wins over m1
    s_ack  = 1'b1;
    s_rdat = 32'h0000_1234;
    rst_n  = 1'b0;
    settle();
    check("arst_gnt", 64'(gnt), 64'h0);
    check("arst_scyc", 64'(s_cyc), 64'h0);
    check("arst_sstb", 64'(s_stb), 64'h0);
    check("arst_sadr", 64'(s_adr), 64'h0);
    check("arst_ack", 64'(m_ack), 64'h0);
    check("arst_m1_dat", 64'(m_rdat[1]), 64'h0);
    s_ack = 1'b0;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    check("arst_m0_first", 64'(gnt), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
